// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// The optional checksum trailer is enabled by defining IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_AW    = 6;
  localparam int DEF_DEPTH = 64;
  localparam int BPW       = DEF_N / 8;
  localparam int MAX_WORDS = DEF_DEPTH;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } ldr_state_t;

  // A header is unusable if it announces no words or more than the RAM holds.
  function automatic logic hdr_bad(input logic [7:0] c, input int depth);
    return (c == 8'd0) || (int'(c) > depth);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into N-bit words, one byte lane per push.
// full means the word holds N/8-1 bytes, so the next push completes it.
module imem_word_packer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [7:0]   data,
  output logic [N-1:0] word,
  output logic         full
);

  localparam int NB = N / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0] byte_idx_reg;
  logic [7:0]    lane_reg [NB];

  assign full = (byte_idx_reg == IW'(NB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_reg <= '0;
    end else if (clear) begin
      byte_idx_reg <= '0;
    end else if (push) begin
      byte_idx_reg <= full ? '0 : byte_idx_reg + IW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg[gi] <= '0;
        end else if (clear) begin
          lane_reg[gi] <= '0;
        end else if (push && (byte_idx_reg == IW'(gi))) begin
          lane_reg[gi] <= data;
        end
      end
      assign word[8*gi +: 8] = lane_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Loads a header-prefixed byte image into the instruction RAM and holds the CPU until done.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = MAX_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic          err
);

  ldr_state_t    state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic [7:0]    words_left_reg;

  logic          pk_clear;
  logic          pk_push;
  logic          pk_full;
  logic [N-1:0]  pk_word;
  logic          hdr_load;
  logic          wr_step;

  imem_word_packer #(.N(N)) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (pk_clear),
    .push  (pk_push),
    .data  (in_data),
    .word  (pk_word),
    .full  (pk_full)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_reg <= '0;
    end else if (pk_clear) begin
      csum_reg <= '0;
    end else if (pk_push) begin
      csum_reg <= csum_reg ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The address only advances between words, so the final write stays at C-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg       <= '0;
      words_left_reg <= '0;
    end else if (hdr_load) begin
      addr_reg       <= '0;
      words_left_reg <= in_data;
    end else if (wr_step) begin
      words_left_reg <= words_left_reg - 8'd1;
      if (words_left_reg != 8'd1) begin
        addr_reg <= addr_reg + AW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    hdr_load   = 1'b0;
    wr_step    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          pk_clear   = 1'b1;
          state_next = HDR;
        end
      end

      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (hdr_bad(in_data, DEPTH)) begin
            state_next = ERR;
          end else begin
            hdr_load   = 1'b1;
            state_next = DATA;
          end
        end
      end

      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          pk_push = 1'b1;
          if (pk_full) begin
            state_next = WRITE;
          end
        end
      end

      WRITE: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        wr_step = 1'b1;
        if (words_left_reg == 8'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_next = (in_data == csum_reg) ? DONE : ERR;
        end
      end
`endif

      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) begin
          pk_clear   = 1'b1;
          state_next = HDR;
        end
      end

      ERR: begin
        err = 1'b1;
        if (start) begin
          pk_clear   = 1'b1;
          state_next = HDR;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, packing, latency, depth limit, reset abort.
// Checksum cases are included when IMEM_LOADER_CSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, busy, done, cpu_hold, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;

  int total = 0;
  int bad = 0;
  int we_rdy = 0;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  img[0:255];

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (in_ready) we_rdy++;
      $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic check_write(input int i, input logic [5:0] a, input logic [31:0] d);
    if (i < wr_addr.size()) begin
      check($sformatf("wr%0d_addr", i), {26'b0, wr_addr[i]}, {26'b0, a});
      check($sformatf("wr%0d_data", i), wr_data[i], d);
    end else begin
      check($sformatf("wr%0d_missing", i), wr_addr.size(), i + 1);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("rdy_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] c, input int nbytes, input int maxgap);
    logic [7:0] x;
    x = 8'h00;
    send_byte(c, 0);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      x = x ^ img[i];
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(x, 0);
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(done || err)) check("end_timeout", {31'b0, done | err}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset / idle behaviour
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_writes", wr_addr.size(), 0);
    check("idle_rdy", in_ready, 0);
    check("idle_busy", busy, 0);

    // nominal two-word load
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'hf8;
    img[4] = 8'h02; img[5] = 8'h80; img[6] = 8'h00; img[7] = 8'hf8;
    clear_log();
    pulse_start();
    check("hdr_busy", busy, 1);
    check("hdr_rdy", in_ready, 1);
    send_image(8'h02, 8, 0);
`ifndef IMEM_LOADER_CSUM_EN
    check("lat_we", mem_we, 1);
    check("lat_rdy_in_write", in_ready, 0);
    check("lat_done_early", done, 0);
    @(posedge clk); #1;
    check("lat_done", done, 1);
    check("lat_hold", cpu_hold, 0);
`else
    wait_end();
    check("nom_done", done, 1);
`endif
    check("nom_busy", busy, 0);
    check("nom_cnt", wr_addr.size(), 2);
    check_write(0, 6'd0, 32'hf8000001);
    check_write(1, 6'd1, 32'hf8008002);

    // same image with random gaps, restarted from DONE
    clear_log();
    pulse_start();
    check("restart_done", done, 0);
    check("restart_hold", cpu_hold, 1);
    send_image(8'h02, 8, 3);
    wait_end();
    check("gap_done", done, 1);
    check("gap_cnt", wr_addr.size(), 2);
    check_write(0, 6'd0, 32'hf8000001);
    check_write(1, 6'd1, 32'hf8008002);

    // bad headers, then recovery
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    check("c0_err", err, 1);
    check("c0_hold", cpu_hold, 1);
    check("c0_done", done, 0);
    check("c0_busy", busy, 0);
    pulse_start();
    check("c41_err_clr", err, 0);
    check("c41_busy", busy, 1);
    send_byte(8'h41, 0);
    check("c41_err", err, 1);
    check("bad_writes", wr_addr.size(), 0);
    pulse_start();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    send_image(8'h01, 4, 0);
    wait_end();
    check("rec_done", done, 1);
    check("rec_err", err, 0);
    check("rec_cnt", wr_addr.size(), 1);
    check_write(0, 6'd0, 32'h44332211);

    // full depth: 64 words
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    clear_log();
    pulse_start();
    send_image(8'h40, 256, 0);
    wait_end();
    check("full_done", done, 1);
    check("full_cnt", wr_addr.size(), 64);
    for (int w = 0; w < 64; w++) begin
      check_write(w, 6'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end
    check("full_last_addr", mem_addr, 63);

    // reset in the middle of the second word
    img[0] = 8'haa; img[1] = 8'hbb; img[2] = 8'hcc; img[3] = 8'hdd;
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) send_byte(img[i], 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("mid_addr", mem_addr, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_addr", mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_cnt", wr_addr.size(), 1);
    check_write(0, 6'd0, 32'hddccbbaa);
    clear_log();
    img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h30; img[3] = 8'h40;
    pulse_start();
    send_image(8'h01, 4, 0);
    wait_end();
    check("after_rst_cnt", wr_addr.size(), 1);
    check_write(0, 6'd0, 32'h40302010);

`ifdef IMEM_LOADER_CSUM_EN
    // explicit checksum trailer: good then bad
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hf8, 0);
    send_byte(8'hf9, 0);
    check("csum_ok_done", done, 1);
    check("csum_ok_hold", cpu_hold, 0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hf8, 0);
    send_byte(8'hf8, 0);
    check("csum_bad_err", err, 1);
    check("csum_bad_hold", cpu_hold, 1);
    check("csum_bad_done", done, 0);
    check("csum_cnt", wr_addr.size(), 2);
`endif

    check("we_while_ready", we_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
